signmag_serial_conv: RTL

Multi-cycle, bit-serial converter between 32-bit two's-complement and 32-bit sign-magnitude encodings, in both directions. It sits beside the ALU in the KGP RISC datapath. It serves instructions and debug paths that need sign-magnitude operands or results. A start/busy/done handshake lets the control unit stall on it. Conversion uses the serial complement rule: copy bits up to and including the first 1, then invert every later bit.

---
 rtl/signmag_serial_conv.sv | 114 +++++++++++
 1 files changed

// File: rtl/signmag_serial_conv.sv
//==============================================================================
// Module  : signmag_serial_conv
// Brief   : Bit-serial 32-bit two's-complement <-> sign-magnitude converter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module signmag_serial_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] A,
    output logic [31:0] M,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] c_LAST_BIT = 5'd30;

    logic [1:0]  r_state;
    logic [30:0] r_a;
    logic        r_mode;
    logic [4:0]  r_cnt;
    logic        r_seen_one;
    logic        r_neg;
    logic [30:0] r_res;
    logic [31:0] r_m;
    logic        r_ovf;

    logic        w_in_bit;
    logic        w_out_bit;
    logic [30:0] w_res_next;
    logic [31:0] w_m_final;
    logic        w_ovf_final;

    // Copy bits through the first 1, invert every bit after it.
    assign w_in_bit   = r_a[r_cnt];
    assign w_out_bit  = (r_neg & r_seen_one) ? ~w_in_bit : w_in_bit;
    assign w_res_next = r_res | (31'(w_out_bit) << r_cnt);

    always_comb begin
        w_m_final   = {r_neg, w_res_next};
        w_ovf_final = 1'b0;
        if (r_mode == 1'b0) begin
            // -2^31 has no sign-magnitude form: saturate and flag.
            if (r_neg && (w_res_next == 31'd0)) begin
                w_m_final   = 32'hFFFF_FFFF;
                w_ovf_final = 1'b1;
            end
        end else begin
            // Negative zero collapses to plain zero.
            w_m_final = {r_neg & (|r_a), w_res_next};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_mode     <= 1'b0;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_neg      <= 1'b0;
            r_res      <= '0;
            r_m        <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a        <= A[30:0];
                        r_mode     <= mode;
                        r_neg      <= A[31];
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_res      <= '0;
                        r_ovf      <= 1'b0;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_res      <= w_res_next;
                    r_seen_one <= r_seen_one | w_in_bit;
                    r_cnt      <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_BIT) begin
                        r_m     <= w_m_final;
                        r_ovf   <= w_ovf_final;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign M    = r_m;
    assign ovf  = r_ovf;
    assign busy = (r_state == S_CONV) || (r_state == S_DONE);
    assign done = (r_state == S_DONE);

endmodule

`default_nettype wire
